// File: rtl/cam_arbiter.sv
// Two-requester round-robin front end for an external CAM: serialises lookups and
// inserts, allocates entries sequentially and reports hit/index/full per request.
module cam_arbiter #(
  parameter int NB_MEM = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_op,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic [1:0] req_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic       rsp_hit,
  output logic [3:0] rsp_idx,
  output logic       rsp_full,
  output logic       cam_enable,
  output logic       cam_write,
  output logic [4:0] cam_addr,
  output logic [7:0] cam_data,
  input  logic [4:0] cam_out,
  input  logic       cam_found
);

  typedef enum logic [2:0] {IDLE, LOOK, CHECK, WRITE, RESP} state_t;

  state_t     state_q, state_d;
  logic       grant_id_q, grant_id_d;
  logic       last_q, last_d;
  logic       op_q, op_d;
  logic [7:0] key_q, key_d;
  logic       hit_q, hit_d;
  logic [3:0] idx_q, idx_d;
  logic       full_q, full_d;
  logic [3:0] fill_ptr_q, fill_ptr_d;
  logic [4:0] fill_cnt_q, fill_cnt_d;

  logic       grant_sel;
  logic       unused_cam_bit;

  assign unused_cam_bit = cam_out[4];

  // When both request, the one not served last wins; last_q resets to 1 so requester 0 goes first.
  always_comb begin
    if (req_valid == 2'b11) grant_sel = ~last_q;
    else                    grant_sel = req_valid[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= 1'b0;
      last_q     <= 1'b1;
      op_q       <= 1'b0;
      key_q      <= 8'h00;
      hit_q      <= 1'b0;
      idx_q      <= 4'h0;
      full_q     <= 1'b0;
      fill_ptr_q <= 4'h0;
      fill_cnt_q <= 5'h00;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      op_q       <= op_d;
      key_q      <= key_d;
      hit_q      <= hit_d;
      idx_q      <= idx_d;
      full_q     <= full_d;
      fill_ptr_q <= fill_ptr_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    op_d       = op_q;
    key_d      = key_q;
    hit_d      = hit_q;
    idx_d      = idx_q;
    full_d     = full_q;
    fill_ptr_d = fill_ptr_q;
    fill_cnt_d = fill_cnt_q;
    req_ready  = 2'b00;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_hit    = 1'b0;
    rsp_idx    = 4'h0;
    rsp_full   = 1'b0;
    cam_enable = 1'b0;
    cam_write  = 1'b0;
    cam_addr   = 5'h00;
    cam_data   = 8'h00;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // Gate with rst_n so the accept pulse is also forced low while reset is held.
          req_ready  = rst_n ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
          grant_id_d = grant_sel;
          last_d     = grant_sel;
          op_d       = req_op[grant_sel];
          key_d      = grant_sel ? req1_data : req0_data;
          state_d    = LOOK;
        end
      end
      LOOK: begin
        cam_enable = 1'b1;
        cam_data   = key_q;
        state_d    = CHECK;
      end
      CHECK: begin
        hit_d  = cam_found;
        idx_d  = cam_found ? cam_out[3:0] : 4'h0;
        full_d = 1'b0;
        if (!op_q || cam_found) begin
          state_d = RESP;
        end else if (fill_cnt_q == 5'(NB_MEM)) begin
          full_d  = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        cam_write  = 1'b1;
        cam_addr   = {1'b0, fill_ptr_q};
        cam_data   = key_q;
        idx_d      = fill_ptr_q;
        // Pointer parks on the last entry; the count alone decides fullness.
        fill_ptr_d = (fill_ptr_q == 4'(NB_MEM - 1)) ? fill_ptr_q : fill_ptr_q + 4'd1;
        fill_cnt_d = (fill_cnt_q == 5'(NB_MEM)) ? fill_cnt_q : fill_cnt_q + 5'd1;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = grant_id_q;
        rsp_hit   = hit_q;
        rsp_idx   = idx_q;
        rsp_full  = full_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cam_arbiter.sv
// Directed bench for cam_arbiter with a small behavioural CAM attached.
module tb_cam_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_op;
  logic [7:0] req0_data, req1_data;
  logic [1:0] req_ready;
  logic       rsp_valid, rsp_id, rsp_hit, rsp_full;
  logic [3:0] rsp_idx;
  logic       cam_enable, cam_write;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic [4:0] cam_out;
  logic       cam_found;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  int rsp_cnt = 0;
  int strobe_ovl = 0;
  int ready_ovl = 0;
  logic [4:0] last_wr_addr = 5'h1f;

  always #5 clk = ~clk;

  cam_arbiter #(.NB_MEM(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req0_data(req0_data), .req1_data(req1_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_hit(rsp_hit),
    .rsp_idx(rsp_idx), .rsp_full(rsp_full),
    .cam_enable(cam_enable), .cam_write(cam_write),
    .cam_addr(cam_addr), .cam_data(cam_data),
    .cam_out(cam_out), .cam_found(cam_found)
  );

  // Behavioural CAM: result registered one cycle after cam_enable, cleared by rst_n.
  logic [7:0]  cam_key [16];
  logic [15:0] cam_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_v     <= '0;
      cam_found <= 1'b0;
      cam_out   <= 5'h00;
    end else begin
      cam_found <= 1'b0;
      cam_out   <= 5'h00;
      if (cam_write) begin
        cam_key[cam_addr[3:0]] <= cam_data;
        cam_v[cam_addr[3:0]]   <= 1'b1;
      end
      if (cam_enable) begin
        for (int i = 0; i < 16; i++) begin
          if (cam_v[i] && cam_key[i] == cam_data) begin
            cam_found <= 1'b1;
            cam_out   <= 5'(i);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (cam_write) begin
      wr_cnt++;
      last_wr_addr = cam_addr;
    end
    if (cam_enable && cam_write) strobe_ovl++;
    if (req_ready == 2'b11) ready_ovl++;
    if (rsp_valid) rsp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit id, input bit op, input logic [7:0] key,
                        input bit ehit, input logic [3:0] eidx, input bit efull, input int elat);
    int n;
    int lat;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    if (id) req1_data = key; else req0_data = key;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant", 32'(req_ready[id]), 32'd1);
    @(negedge clk);
    req_valid[id] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk); lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_hit", 32'(rsp_hit), 32'(ehit));
    check("rsp_idx", 32'(rsp_idx), 32'(eidx));
    check("rsp_full", 32'(rsp_full), 32'(efull));
    $display("req id=%0d op=%0d key=0x%02h -> lat=%0d hit=%0d idx=%0d full=%0d",
             id, op, key, lat, rsp_hit, rsp_idx, rsp_full);
    @(negedge clk);
    check("rsp_idle", 32'({rsp_valid, rsp_hit, rsp_idx, rsp_full}), 32'd0);
  endtask

  initial begin
    logic [1:0] gseq [4];
    int n, ng, rc, wc;

    rst_n = 1'b0;
    req_valid = 2'b11;
    req_op = 2'b00;
    req0_data = 8'h00;
    req1_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_hit, rsp_idx, rsp_full,
                             cam_enable, cam_write, cam_addr, cam_data}), 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // First insert allocates entry 0.
    do_req(0, 1, 8'h5A, 0, 4'd0, 0, 4);
    check("ins_wr_cnt", 32'(wr_cnt), 32'd1);
    check("ins_wr_addr", 32'(last_wr_addr), 32'd0);

    // Duplicate insert and lookup both hit entry 0 without writing.
    do_req(0, 1, 8'h5A, 1, 4'd0, 0, 3);
    do_req(1, 0, 8'h5A, 1, 4'd0, 0, 3);
    check("dup_no_wr", 32'(wr_cnt), 32'd1);

    // Continuous contention: grants alternate starting with requester 0.
    @(negedge clk);
    req_op = 2'b00;
    req0_data = 8'h5A;
    req1_data = 8'h77;
    req_valid = 2'b11;
    #1;
    ng = 0;
    n = 0;
    while (ng < 4 && n < 60) begin
      if (req_ready != 2'b00) begin
        gseq[ng] = req_ready;
        $display("grant %0d: req_ready=%b", ng, req_ready);
        ng++;
      end
      @(negedge clk); #1; n++;
    end
    req_valid = 2'b00;
    check("rr_count", 32'(ng), 32'd4);
    check("rr_g0", 32'(gseq[0]), 32'd1);
    check("rr_g1", 32'(gseq[1]), 32'd2);
    check("rr_g2", 32'(gseq[2]), 32'd1);
    check("rr_g3", 32'(gseq[3]), 32'd2);
    repeat (6) @(negedge clk);
    check("ready_overlap", 32'(ready_ovl), 32'd0);

    // Absent key.
    do_req(1, 0, 8'hC3, 0, 4'd0, 0, 3);

    // Reset in the middle of a write.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_op[0] = 1'b1;
    req0_data = 8'h11;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("abort_grant", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_write", 32'(cam_write), 32'd1);
    rc = rsp_cnt;
    wc = wr_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("abort_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_hit, rsp_idx, rsp_full,
                             cam_enable, cam_write, cam_addr, cam_data}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_rsp", 32'(rsp_cnt - rc), 32'd0);
    check("abort_no_wr", 32'(wr_cnt - wc), 32'd0);
    do_req(0, 1, 8'h22, 0, 4'd0, 0, 4);
    check("post_rst_addr", 32'(last_wr_addr), 32'd0);

    // Fill the remaining fifteen entries, then overflow.
    for (int i = 0; i < 15; i++)
      do_req(i[0], 1, 8'(8'h30 + i), 0, 4'(i + 1), 0, 4);
    check("fill_last_addr", 32'(last_wr_addr), 32'd15);
    wc = wr_cnt;
    do_req(0, 1, 8'hEE, 0, 4'd0, 1, 3);
    check("full_no_wr", 32'(wr_cnt - wc), 32'd0);
    do_req(1, 0, 8'h3E, 1, 4'd15, 0, 3);
    check("strobe_overlap", 32'(strobe_ovl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_arbiter.md
CAM_ARBITER -- requirements
Module: cam_arbiter

Parameters
REQ-001 The block SHALL have parameter NB_MEM, default 16, meaning the number of CAM entries; the fill pointer range is 0..NB_MEM-1.

Interface
REQ-002 The block SHALL have port clk, input, width 1: the single clock, all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, width 2: requests from requester 0 (bit 0) and requester 1 (bit 1).
REQ-005 The block SHALL have port req_op, input, width 2: per-requester operation, 0=lookup, 1=insert.
REQ-006 The block SHALL have ports req0_data and req1_data, input, width 8 each: per-requester key.
REQ-007 The block SHALL have port req_ready, output, width 2: one-cycle accept pulse per requester.
REQ-008 The block SHALL have port rsp_valid, output, width 1: response strobe, one cycle.
REQ-009 The block SHALL have port rsp_id, output, width 1: index of the requester being answered.
REQ-010 The block SHALL have port rsp_hit, output, width 1: key present in the CAM.
REQ-011 The block SHALL have port rsp_idx, output, width 4: matching entry on hit, written entry on insert.
REQ-012 The block SHALL have port rsp_full, output, width 1: insert refused, table full.
REQ-013 The block SHALL have ports cam_enable, cam_write, output, width 1 each: CAM strobes.
REQ-014 The block SHALL have port cam_addr, output, width 5, with bit 4 always 0.
REQ-015 The block SHALL have port cam_data, output, width 8: key to the CAM.
REQ-016 The block SHALL have ports cam_out, input, width 5 (bit 4 ignored), and cam_found, input, width 1: CAM results, registered by the CAM one cycle after cam_enable.

Function
REQ-017 The FSM SHALL have states IDLE, LOOK, CHECK, WRITE, RESP.
REQ-018 In IDLE with any req_valid bit set, the block SHALL grant exactly one requester, pulse its req_ready bit for that cycle, latch its op and data, and go to LOOK.
REQ-019 Arbitration SHALL be round-robin: when both request, the requester not granted last wins; after reset, requester 0 has priority.
REQ-020 In LOOK, the block SHALL drive cam_enable=1, cam_write=0, cam_data=latched key, then go to CHECK.
REQ-021 In CHECK, the block SHALL sample cam_found and cam_out[3:0].
REQ-022 From CHECK, a lookup SHALL go to RESP.
REQ-023 From CHECK, an insert with a hit SHALL go to RESP with rsp_hit=1, rsp_idx=matched entry, and no write.
REQ-024 From CHECK, an insert with a miss when fill_cnt==NB_MEM SHALL go to RESP with rsp_full=1, rsp_hit=0, and no write.
REQ-025 From CHECK, an insert with a miss otherwise SHALL go to WRITE.
REQ-026 In WRITE, the block SHALL drive cam_write=1, cam_addr={0,fill_ptr}, cam_data=key, set rsp_idx=fill_ptr, increment fill_ptr and fill_cnt, and go to RESP.
REQ-027 In RESP, the block SHALL assert rsp_valid for exactly one cycle with rsp_id=granted requester, then return to IDLE; req_valid is ignored in RESP.
REQ-028 Latency SHALL be: lookup or insert-hit/full, rsp_valid 3 cycles after the req_ready cycle; insert-miss, 4 cycles.
REQ-029 fill_cnt (5 bits) SHALL saturate at NB_MEM; fill_ptr (4 bits) SHALL never wrap, because a write is refused once full.
REQ-030 Outside LOOK and WRITE, cam_enable, cam_write, cam_addr and cam_data SHALL be 0.
REQ-031 rsp_hit, rsp_idx and rsp_full SHALL be valid only while rsp_valid=1 and SHALL be 0 otherwise.
REQ-032 At most one CAM strobe SHALL be high in any cycle, and at most one operation SHALL be in flight.

Reset
REQ-033 On rst_n low, at any time including mid-operation, the block SHALL immediately force: state IDLE, all outputs 0, fill_ptr=0, fill_cnt=0, round-robin priority to requester 0.
REQ-034 An in-flight operation aborted by reset SHALL produce no response; the CAM shares rst_n and clears with it.

Verification
REQ-035 Insert key 0x5A from requester 0 after reset -> cam_write at addr 0; rsp_valid 4 cycles after ready; rsp_hit=0, rsp_idx=0, rsp_full=0.
REQ-036 Insert 0x5A again, then lookup 0x5A from requester 1 -> both respond rsp_hit=1, rsp_idx=0 after 3 cycles; no second write; rsp_id=1 for the lookup.
REQ-037 Both requesters hold req_valid continuously with lookups -> grants alternate 0,1,0,1; no req_ready overlap.
REQ-038 Sixteen distinct inserts, then insert 0xEE -> seventeenth response has rsp_full=1, rsp_hit=0; no cam_write issued.
REQ-039 Lookup of an absent key -> rsp_hit=0, rsp_idx=0.
REQ-040 Assert rst_n low during WRITE -> outputs 0 immediately, no rsp_valid; the next insert writes addr 0.
